// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   OVERSAMPLE   : sample ticks per bit period
//   uart_state_e : line FSM states (3-bit)
//   calc_div     : clk cycles per sample tick, rounded to nearest
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // freq / (OVERSAMPLE * baud), rounded to nearest integer
  function automatic int unsigned calc_div(input longint unsigned freq,
                                           input longint unsigned baud);
    longint unsigned den;
    den = baud * 64'(OVERSAMPLE);
    return 32'((freq + (den >> 1)) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick enable generator: one-clk pulse on tick every DIV clks.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous reset, active low
//   restart in   hold counter at phase 0 (first tick lands DIV clks after release)
//   tick    out  registered one-clk enable
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  // tick is registered, so it is decoded one count early to keep the
  // first pulse exactly DIV clks after restart is released
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_baud_tick: DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter with early-decoded tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == PRE);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, start/stop validated, valid/ready output.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active low
//   rx        in   serial line, idle high, asynchronous to clk
//   data      out  received word, stable while valid and not consumed
//   valid     out  data holds an unconsumed frame
//   ready     in   consumer accepts data when valid && ready
//   frame_err out  one-clk pulse: stop bit sampled low
//   overrun   out  one-clk pulse: good frame dropped, output still occupied
//   busy      out  FSM is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned NATIVE_CLK_FREQUENCY = 1000000000,
  parameter int unsigned BAUDRATE             = 9600,
  parameter int unsigned FRAME_DATA_LENGTH    = 8,
  parameter bit          ENABLE_BIG_ENDIAN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [FRAME_DATA_LENGTH-1:0] data,
  output logic                         valid,
  input  logic                         ready,
  output logic                         frame_err,
  output logic                         overrun,
  output logic                         busy
);

  localparam int unsigned W   = FRAME_DATA_LENGTH;
  localparam int unsigned DIV = calc_div(64'(NATIVE_CLK_FREQUENCY), 64'(BAUDRATE));
  localparam int unsigned BCW = $clog2(W + 1);
  localparam int unsigned TCW = $clog2(OVERSAMPLE);

  // Start bit is checked at its centre, data/stop bits one full period apart
  localparam logic [TCW-1:0] START_TICK = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] LAST_TICK  = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(W - 1);

  generate
    if (W < 1 || W > 16) begin : g_len_check
      $error("uart_receiver: FRAME_DATA_LENGTH must be 1..16");
    end
  endgenerate

  logic           rx_meta;
  logic           rxs;
  logic           tick;
  logic           restart_c;
  uart_state_e    state;
  logic [TCW-1:0] tick_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [W-1:0]   shreg;

  // Insert one sampled bit according to the configured bit order
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic b);
    if (ENABLE_BIG_ENDIAN)
      return (cur << 1) | W'(b);
    else
      return (cur >> 1) | (W'(b) << (W - 1));
  endfunction

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Tick phase is held at zero while idle so the frame timing starts at the edge
  assign restart_c = (state == IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart_c),
    .tick   (tick)
  );

  // Line FSM, shift register and output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            busy     <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == START_TICK) begin
              tick_cnt <= '0;
              if (rxs) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TCW'(1);
            end
          end
        end

        DATA: begin
          if (tick) begin
            // wraps to zero after the last tick of each bit
            tick_cnt <= tick_cnt + TCW'(1);
            if (tick_cnt == LAST_TICK) begin
              shreg <= shift_in(shreg, rxs);
              if (bit_cnt == LAST_BIT) begin
                state   <= STOP;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + TCW'(1);
            if (tick_cnt == LAST_TICK) begin
              if (rxs) begin
                state <= IDLE;
                busy  <= 1'b0;
                // free slot, or slot being consumed this very clk
                if (!valid || ready) begin
                  data  <= shreg;
                  valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end
          end
        end

        BREAK: begin
          // a held-low line reports once, then waits for idle
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: one LSB-first and one MSB-first
// instance, a frame-event model checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned NATIVE  = 1600000;
  localparam int unsigned BAUD    = 10000;
  localparam int          BIT_CLK = 160;
  // stop-bit centre (9.5 bit periods) + 2 sync clks + 1 output clk
  localparam int          FRAME_LAT = 9 * BIT_CLK + BIT_CLK / 2 + 3;

  logic       clk;
  logic       rst_n;
  logic       rx[2];
  logic       ready[2];
  logic [7:0] data[2];
  logic       valid[2];
  logic       frame_err[2];
  logic       overrun[2];
  logic       busy[2];

  int cyc;
  int total;
  int bad;
  int ferr_cnt[2];
  int ovr_cnt[2];

  typedef struct {
    int         d;
    int         t;
    logic [7:0] w;
    bit         good;
  } ev_t;

  ev_t        evq[$];
  logic       m_valid[2];
  logic [7:0] m_data[2];
  logic       ready_prev[2];

  uart_receiver #(
    .NATIVE_CLK_FREQUENCY(NATIVE),
    .BAUDRATE(BAUD),
    .FRAME_DATA_LENGTH(8),
    .ENABLE_BIG_ENDIAN(1'b0)
  ) dut_le (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data(data[0]), .valid(valid[0]),
    .ready(ready[0]), .frame_err(frame_err[0]), .overrun(overrun[0]), .busy(busy[0])
  );

  uart_receiver #(
    .NATIVE_CLK_FREQUENCY(NATIVE),
    .BAUDRATE(BAUD),
    .FRAME_DATA_LENGTH(8),
    .ENABLE_BIG_ENDIAN(1'b1)
  ) dut_be (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data(data[1]), .valid(valid[1]),
    .ready(ready[1]), .frame_err(frame_err[1]), .overrun(overrun[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame in the bit order the addressed instance expects
  task automatic send(input int d, input logic [7:0] w, input bit stop_ok);
    ev_t e;
    tick();
    rx[d] = 1'b0;
    e.d = d; e.t = cyc + FRAME_LAT; e.w = w; e.good = stop_ok;
    evq.push_back(e);
    repeat (BIT_CLK) tick();
    for (int i = 0; i < 8; i++) begin
      rx[d] = (d == 1) ? w[7 - i] : w[i];
      repeat (BIT_CLK) tick();
    end
    rx[d] = stop_ok;
    repeat (BIT_CLK) tick();
  endtask

  task automatic consume(input int d);
    tick();
    ready[d] = 1'b1;
    tick();
    ready[d] = 1'b0;
  endtask

  // ready high only in the clk whose edge samples the stop bit
  task automatic pulse_ready(input int d, input int off);
    int t;
    tick();
    t = cyc;
    while (cyc < t + off) tick();
    ready[d] = 1'b1;
    tick();
    ready[d] = 1'b0;
  endtask

  task automatic busy_window(input int d);
    int t;
    tick();
    t = cyc;
    while (cyc < t + 2) tick();
    chk("busy_before_sync", busy[d], 0);
    tick();
    chk("busy_after_start", busy[d], 1);
    while (cyc < t + FRAME_LAT - 1) tick();
    chk("busy_before_stop", busy[d], 1);
    tick();
    chk("busy_after_stop", busy[d], 0);
  endtask

  // Model: completed frames arrive as timed events; the output slot follows
  // the handshake rules. All outputs are compared every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic hs;
      logic m_ferr;
      logic m_ovr;
      if (!rst_n) begin
        m_valid[d]    = 1'b0;
        ready_prev[d] = 1'b0;
        chk($sformatf("rst_valid%0d", d), valid[d], 0);
        chk($sformatf("rst_data%0d", d), data[d], 0);
        chk($sformatf("rst_ferr%0d", d), frame_err[d], 0);
        chk($sformatf("rst_ovr%0d", d), overrun[d], 0);
        chk($sformatf("rst_busy%0d", d), busy[d], 0);
      end else begin
        hs     = m_valid[d] && ready_prev[d];
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (hs) m_valid[d] = 1'b0;
        if (evq.size() > 0 && evq[0].t == cyc && evq[0].d == d) begin
          ev_t e;
          e = evq.pop_front();
          if (!e.good) m_ferr = 1'b1;
          else if (!m_valid[d]) begin
            m_valid[d] = 1'b1;
            m_data[d]  = e.w;
          end else m_ovr = 1'b1;
        end
        chk($sformatf("valid%0d@%0d", d, cyc), valid[d], m_valid[d]);
        if (m_valid[d]) chk($sformatf("data%0d@%0d", d, cyc), data[d], m_data[d]);
        chk($sformatf("frame_err%0d@%0d", d, cyc), frame_err[d], m_ferr);
        chk($sformatf("overrun%0d@%0d", d, cyc), overrun[d], m_ovr);
        ready_prev[d] = ready[d];
      end
      if (frame_err[d] === 1'b1) ferr_cnt[d]++;
      if (overrun[d] === 1'b1) ovr_cnt[d]++;
    end
    if (!rst_n) evq.delete();
  end

  initial begin
    int t;
    rst_n = 1'b0;
    rx[0] = 1'b1; rx[1] = 1'b1;
    ready[0] = 1'b0; ready[1] = 1'b0;
    repeat (5) tick();
    chk("reset_valid", valid[0], 0);
    chk("reset_data", data[1], 0);
    rst_n = 1'b1;
    repeat (20) tick();

    // LSB-first frames
    send(0, 8'hA5, 1'b1);
    chk("t1_data_a5", data[0], 8'hA5);
    chk("t1_valid", valid[0], 1);
    consume(0);
    send(0, 8'h1D, 1'b1);
    chk("t1_data_1d", data[0], 8'h1D);
    consume(0);
    chk("t1_valid_fell", valid[0], 0);

    // MSB-first frame with busy window
    fork
      send(1, 8'h3C, 1'b1);
      busy_window(1);
    join
    chk("t2_data_3c", data[1], 8'h3C);
    consume(1);
    send(1, 8'hC4, 1'b1);
    chk("t2_data_c4", data[1], 8'hC4);
    consume(1);

    // Short low glitch is rejected
    tick();
    t = cyc;
    rx[0] = 1'b0;
    repeat (40) tick();
    rx[0] = 1'b1;
    while (cyc < t + 50) tick();
    chk("t3_busy_in_start", busy[0], 1);
    while (cyc < t + 200) tick();
    chk("t3_busy_back", busy[0], 0);
    chk("t3_no_valid", valid[0], 0);
    chk("t3_no_ferr", ferr_cnt[0], 0);

    // Bad stop bit, line held low, then recovery
    send(1, 8'h55, 1'b0);
    repeat (340) tick();
    chk("t4_busy_in_break", busy[1], 1);
    rx[1] = 1'b1;
    repeat (200) tick();
    chk("t4_busy_idle", busy[1], 0);
    chk("t4_one_ferr", ferr_cnt[1], 1);
    chk("t4_no_valid", valid[1], 0);
    send(1, 8'h11, 1'b1);
    chk("t4_data_11", data[1], 8'h11);
    chk("t4_still_one_ferr", ferr_cnt[1], 1);
    consume(1);

    // Overrun while output is occupied
    send(0, 8'h01, 1'b1);
    send(0, 8'h02, 1'b1);
    chk("t5_data_kept", data[0], 8'h01);
    chk("t5_valid", valid[0], 1);
    chk("t5_one_ovr", ovr_cnt[0], 1);
    consume(0);
    chk("t5_valid_fell", valid[0], 0);

    // Handshake in the same clk as frame completion
    send(1, 8'h4B, 1'b1);
    chk("t6_data_4b", data[1], 8'h4B);
    fork
      send(1, 8'hD2, 1'b1);
      pulse_ready(1, FRAME_LAT - 1);
    join
    chk("t6_data_d2", data[1], 8'hD2);
    chk("t6_valid", valid[1], 1);
    chk("t6_no_ovr", ovr_cnt[1], 0);
    consume(1);

    // Reset mid-DATA with a word pending
    send(0, 8'h99, 1'b1);
    chk("t7_data_99", data[0], 8'h99);
    tick();
    rx[0] = 1'b0;
    repeat (400) tick();
    chk("t7_busy_mid", busy[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_data", data[0], 0);
    chk("t7_async_valid", valid[0], 0);
    chk("t7_async_busy", busy[0], 0);
    rx[0] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    send(0, 8'h7E, 1'b1);
    chk("t7_data_7e", data[0], 8'h7E);
    consume(0);

    repeat (10) tick();
    chk("events_drained", evq.size(), 0);
    chk("no_ferr_le", ferr_cnt[0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
